// File: rtl/mz_router_stage_pkg.sv
// Shared definitions for the MAZE router stage: port indices, fault codes,
// packet types, FSM states and packet field offsets.
package maze_pkg;

    localparam logic [2:0] DIR_N = 3'd0;
    localparam logic [2:0] DIR_W = 3'd1;
    localparam logic [2:0] DIR_S = 3'd2;
    localparam logic [2:0] DIR_E = 3'd3;
    localparam logic [2:0] DIR_B = 3'd4;

    typedef enum logic [3:0] {
        NORMAL  = 4'd0,
        N_OF_x  = 4'd1,
        NE_OF_x = 4'd2,
        E_OF_x  = 4'd3,
        SE_OF_x = 4'd4,
        S_OF_x  = 4'd5,
        SW_OF_x = 4'd6,
        W_OF_x  = 4'd7,
        NW_OF_x = 4'd8
    } fault_e;

    typedef enum logic [1:0] {
        PKT_UNI = 2'b00,
        PKT_XMC = 2'b01,
        PKT_YMC = 2'b10,
        PKT_BC  = 2'b11
    } pkt_type_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ROUTE,
        ST_ISSUE
    } rstate_e;

    // Packet layout, LSB up: data, qos(1), tgt_x, tgt_y, src, type(2)
    function automatic int tgt_x_lsb(int dw);
        return dw + 1;
    endfunction

    function automatic int tgt_y_lsb(int cw, int dw);
        return dw + 1 + cw;
    endfunction

    function automatic int type_lsb(int cw, int dw);
        return dw + 1 + 4 * cw;
    endfunction

endpackage

// File: rtl/mz_router_stage_if.sv
// Input link and allocator-facing signals of one router input port.
interface mz_router_stage_if #(
    parameter int PKT_W = 23
);
    logic             in_valid;
    logic             in_ready;
    logic [PKT_W-1:0] in_pkt;
    logic [2:0]       in_dir;
    logic [4:0]       route_req;
    logic [4:0]       out_gnt;
    logic [PKT_W-1:0] pkt_out;

    modport master (
        output in_valid, in_pkt, in_dir, out_gnt,
        input  in_ready, route_req, pkt_out
    );

    modport slave (
        input  in_valid, in_pkt, in_dir, out_gnt,
        output in_ready, route_req, pkt_out
    );
endinterface

// File: rtl/mz_router_stage_fifo.sv
// Synchronous FIFO holding {arrival dir, packet}; pointers carry a wrap bit
// so full and empty are distinguished without a counter.
module mz_pkt_fifo #(
    parameter int W     = 26,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
    logic         do_push, do_pop;

    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign empty   = (wr_q == rd_q);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_q[AW-1:0]];

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (do_push) wr_d = wr_q + {{AW{1'b0}}, 1'b1};
        if (do_pop)  rd_d = rd_q + {{AW{1'b0}}, 1'b1};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= din;
    end
endmodule

// File: rtl/mz_router_stage.sv
// Fault-aware input router stage: FIFO, one-shot route computation per head
// packet, and a multi-hot request held until every destination is granted.
module mz_router_stage
    import maze_pkg::*;
#(
    parameter int MESH_X     = 8,
    parameter int MESH_Y     = 8,
    parameter int COORD_W    = 3,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int ERR_W      = 16
) (
    input  logic               clk,
    input  logic               rst,
    mz_router_stage_if.slave   bus,
    input  logic [COORD_W-1:0] local_x,
    input  logic [COORD_W-1:0] local_y,
    input  logic [3:0]         fault_register,
    output logic [ERR_W-1:0]   err_cnt
);
    localparam int PKT_W  = 3 + 4 * COORD_W + DATA_W;
    localparam int HW     = PKT_W + 3;
    localparam int TX_LSB = tgt_x_lsb(DATA_W);
    localparam int TY_LSB = tgt_y_lsb(COORD_W, DATA_W);
    localparam int TP_LSB = type_lsb(COORD_W, DATA_W);
    localparam logic [COORD_W-1:0] X_MAX = COORD_W'(MESH_X - 1);
    localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(MESH_Y - 1);

    // Returns {dead_end, mask[B,E,S,W,N]}
    function automatic logic [5:0] route_fn(
        input logic [1:0]         t,
        input logic [COORD_W-1:0] tx, ty, lx, ly,
        input logic [2:0]         d,
        input logic [3:0]         f
    );
        logic [4:0] m;
        logic       dead;
        logic       e_blk, w_blk, n_blk, s_blk;
        m     = '0;
        dead  = 1'b0;
        e_blk = f inside {E_OF_x, NE_OF_x, SE_OF_x};
        w_blk = f inside {W_OF_x, NW_OF_x, SW_OF_x};
        n_blk = f inside {N_OF_x, NW_OF_x, NE_OF_x};
        s_blk = f inside {S_OF_x, SW_OF_x, SE_OF_x};
        case (pkt_type_e'(t))
            PKT_UNI: begin
                if (tx == lx && ty == ly)         m[DIR_B] = 1'b1;
                else if (tx != lx) begin
                    if (tx > lx && !e_blk)        m[DIR_E] = 1'b1;
                    else if (tx < lx && !w_blk)   m[DIR_W] = 1'b1;
                    else if (ty > ly && ly != Y_MAX) m[DIR_N] = 1'b1;
                    else if (ly != '0)            m[DIR_S] = 1'b1;
                end else begin
                    if (ty > ly && !n_blk)        m[DIR_N] = 1'b1;
                    else if (ty < ly && !s_blk)   m[DIR_S] = 1'b1;
                    else if (lx != X_MAX)         m[DIR_E] = 1'b1;
                    else if (lx != '0)            m[DIR_W] = 1'b1;
                end
            end
            PKT_XMC: begin
                if (tx != lx) begin
                    if (tx > lx) m[DIR_E] = 1'b1;
                    else         m[DIR_W] = 1'b1;
                end else begin
                    m[DIR_B] = 1'b1;
                    m[DIR_N] = (d != DIR_N);
                    m[DIR_S] = (d != DIR_S);
                end
            end
            PKT_YMC: begin
                if (ty != ly) begin
                    if (ty > ly) m[DIR_N] = 1'b1;
                    else         m[DIR_S] = 1'b1;
                end else begin
                    m[DIR_B] = 1'b1;
                    m[DIR_E] = (d != DIR_E);
                    m[DIR_W] = (d != DIR_W);
                end
            end
            default: begin
                m[DIR_B] = 1'b1;
                case (d)
                    DIR_B:   m[3:0] = 4'b1111;
                    DIR_W:   begin m[DIR_E] = 1'b1; m[DIR_N] = 1'b1; m[DIR_S] = 1'b1; end
                    DIR_E:   begin m[DIR_W] = 1'b1; m[DIR_N] = 1'b1; m[DIR_S] = 1'b1; end
                    DIR_S:   m[DIR_N] = 1'b1;
                    DIR_N:   m[DIR_S] = 1'b1;
                    default: ;
                endcase
            end
        endcase
        // Never request a port that leaves the mesh
        if (lx == '0)    m[DIR_W] = 1'b0;
        if (lx == X_MAX) m[DIR_E] = 1'b0;
        if (ly == '0)    m[DIR_S] = 1'b0;
        if (ly == Y_MAX) m[DIR_N] = 1'b0;
        if (pkt_type_e'(t) == PKT_UNI && m == '0) begin
            m[DIR_B] = 1'b1;
            dead     = 1'b1;
        end
        return {dead, m};
    endfunction

    rstate_e          state_q, state_d;
    logic [HW-1:0]    hold_q, hold_d, fifo_dout;
    logic [4:0]       req_q, req_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             fifo_full, fifo_empty, push, pop;
    logic [5:0]       rt;

    assign bus.in_ready  = !fifo_full && !rst;
    assign push          = bus.in_valid && bus.in_ready;
    assign bus.route_req = req_q;
    assign bus.pkt_out   = hold_q[PKT_W-1:0];
    assign err_cnt       = err_q;

    mz_pkt_fifo #(.W(HW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   ({bus.in_dir, bus.in_pkt}),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign rt = route_fn(hold_q[TP_LSB +: 2], hold_q[TX_LSB +: COORD_W],
                         hold_q[TY_LSB +: COORD_W], local_x, local_y,
                         hold_q[PKT_W +: 3], fault_register);

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        req_d   = req_q;
        err_d   = err_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    hold_d  = fifo_dout;
                    state_d = ST_ROUTE;
                end
            end
            ST_ROUTE: begin
                req_d = rt[4:0];
                if (rt[5] && err_q != '1) err_d = err_q + 1'b1;
                state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                req_d = req_q & ~bus.out_gnt;
                if (req_d == '0) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        hold_d  = fifo_dout;
                        state_d = ST_ROUTE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
            req_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            req_q   <= req_d;
            err_q   <= err_d;
        end
    end
endmodule
